// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a 16-deep first-word-fall-through FIFO with a pop/peek consumer port.
module uart_rx_fifo #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 115200,
  parameter int DIV     = CLK_HZ / (16 * BAUD),
  parameter int FIFO_AW = 4
) (
  input  logic             CLK100,
  input  logic             RST,
  input  logic             RXD,
  input  logic             POP,
  input  logic             ERR_CLR,
  output logic [7:0]       RDATA,
  output logic             RX_VALID,
  output logic [FIFO_AW:0] RX_COUNT,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             PAR_ERR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t          state_reg, state_next;
  logic            rxd_meta_reg, rxs_reg, rxs_prev_reg;
  logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [3:0]      ph_reg, ph_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      sh_reg, sh_next;
  logic            push_reg, push_next;
  logic            frame_set;
  logic            tick, sample;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               frame_err_reg, overrun_reg;
  logic               do_pop, do_push, full, overrun_set;

  // RXD is asynchronous; only the synchronized rxs_reg drives the receiver.
  always_ff @(posedge CLK100) begin
    if (RST) begin
      rxd_meta_reg <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= RXD;
      rxs_reg      <= rxd_meta_reg;
      rxs_prev_reg <= rxs_reg;
    end
  end

  assign tick   = (tick_cnt_reg == TW'(DIV - 1));
  assign sample = tick && (ph_reg == 4'd7);

  always_ff @(posedge CLK100) begin
    if (RST) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      ph_reg       <= '0;
      bit_reg      <= '0;
      sh_reg       <= '0;
      push_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      ph_reg       <= ph_next;
      bit_reg      <= bit_next;
      sh_reg       <= sh_next;
      push_reg     <= push_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set, par_err_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick ? '0 : tick_cnt_reg + TW'(1);
    ph_next       = tick ? ph_reg + 4'd1 : ph_reg;
    bit_next      = bit_reg;
    sh_next       = sh_reg;
    push_next     = 1'b0;
    frame_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // Realign the oversample grid to the start-bit edge.
        if (rxs_prev_reg && !rxs_reg) begin
          state_next    = START;
          tick_cnt_next = '0;
          ph_next       = '0;
          bit_next      = '0;
        end
      end
      START: if (sample) state_next = rxs_reg ? IDLE : DATA;
      DATA: begin
        if (sample) begin
          sh_next  = {rxs_reg, sh_reg[7:1]};
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_set    = ^{sh_reg, rxs_reg};
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rxs_reg) begin
            push_next  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = BRK;
          end
        end
      end
      // A held-low line is one error; wait for it to return high.
      BRK:     if (rxs_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign full        = (count_reg == (FIFO_AW + 1)'(DEPTH));
  assign do_pop      = POP && (count_reg != '0);
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign do_push     = push_reg && (!full || do_pop);
  assign overrun_set = push_reg && full && !do_pop;

  always_ff @(posedge CLK100) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= sh_reg;
        wr_ptr_reg      <= wr_ptr_reg + FIFO_AW'(1);
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      count_reg     <= count_reg + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
      frame_err_reg <= frame_set | (frame_err_reg & ~ERR_CLR);
      overrun_reg   <= overrun_set | (overrun_reg & ~ERR_CLR);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK100) begin
    if (RST) par_err_reg <= 1'b0;
    else     par_err_reg <= par_set | (par_err_reg & ~ERR_CLR);
  end
  assign PAR_ERR = par_err_reg;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign RDATA     = mem[rd_ptr_reg];
  assign RX_VALID  = (count_reg != '0);
  assign RX_COUNT  = count_reg;
  assign FRAME_ERR = frame_err_reg;
  assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued at send time and
// checked by a monitor whenever a POP consumes a valid FIFO head.
module tb_uart_rx_fifo;
  localparam int DIV = 4;           // BAUD below gives 4 clocks per oversample tick
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Cycle (relative to the start-bit drive) on which the stop-bit push is applied.
  localparam int POP_AT = 3 + DIV * (16 * (NB - 1) + 8);

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, pop = 1'b0, err_clr = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid, frame_err, overrun, par_err;
  logic [4:0] rx_count;

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(1_562_500), .FIFO_AW(4)) dut (
    .CLK100(clk), .RST(rst), .RXD(rxd), .POP(pop), .ERR_CLR(err_clr),
    .RDATA(rdata), .RX_VALID(rx_valid), .RX_COUNT(rx_count),
    .FRAME_ERR(frame_err), .OVERRUN(overrun), .PAR_ERR(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every accepted POP must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && pop && rx_valid) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(rdata), -1);
      else                   chk("pop_data", 32'(rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip,
                      input int pop_at);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9]  = (^b) ^ par_flip;
    fr[10] = stop_v;
`else
    fr[9]  = stop_v;
    fr[10] = par_flip | 1'b1;
`endif
    for (int c = 0; c < NB * BIT; c++) begin
      @(posedge clk);
      #1;
      rxd = fr[c / BIT];
      pop = (c == pop_at);
    end
    @(posedge clk);
    #1;
    pop = 1'b0;
  endtask

  task automatic pop1();
    @(posedge clk);
    #1 pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
  endtask

  task automatic clear_errs();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    logic [9:0] fr5a;
    idle(5);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", 32'(rdata), 0);
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_count", 32'(rx_count), 0);
    chk("reset_flags", 32'({frame_err, overrun, par_err}), 0);

    // Two back-to-back frames, then peek and drain.
    exp_q.push_back(8'h55); send(8'h55, 1'b1, 1'b0, -1);
    exp_q.push_back(8'hA3); send(8'hA3, 1'b1, 1'b0, -1);
    idle(4);
    chk("t1_count", 32'(rx_count), 2);
    chk("t1_head", 32'(rdata), 32'h55);
    chk("t1_par_err", 32'(par_err), 0);
    pop1(); pop1(); idle(2);
    chk("t1_valid_after_drain", 32'(rx_valid), 0);

    // Short low glitch: rejected at the start-bit check.
    rxd = 1'b0; idle(20); rxd = 1'b1; idle(2 * BIT);
    chk("t2_count", 32'(rx_count), 0);
    chk("t2_flags", 32'({frame_err, overrun, par_err}), 0);
    pop1(); idle(2);
    chk("t2_empty_pop_count", 32'(rx_count), 0);

    // Framing error followed by a long break, then a clean frame.
    send(8'hA3, 1'b0, 1'b0, -1);
    idle(20 * BIT);
    rxd = 1'b1; idle(2 * BIT);
    chk("t3_frame_err", 32'(frame_err), 1);
    chk("t3_count", 32'(rx_count), 0);
    exp_q.push_back(8'h0F); send(8'h0F, 1'b1, 1'b0, -1);
    idle(4);
    chk("t3_count_after", 32'(rx_count), 1);
    chk("t3_head", 32'(rdata), 32'h0F);
    pop1();

    // Overflow: the 17th byte is dropped.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 1'b0, -1);
    end
    idle(4);
    chk("t4_count", 32'(rx_count), 16);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_head", 32'(rdata), 0);
    for (int i = 0; i < 16; i++) pop1();
    idle(2);
    chk("t4_drained", 32'(rx_count), 0);
    clear_errs(); idle(1);
    chk("t4_err_clr", 32'({frame_err, overrun}), 0);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send(8'(8'h20 + i), 1'b1, 1'b0, -1);
    end
    idle(4);
    chk("t5_full", 32'(rx_count), 16);
    exp_q.push_back(8'h30);
    send(8'h30, 1'b1, 1'b0, POP_AT);
    idle(4);
    chk("t5_count", 32'(rx_count), 16);
    chk("t5_overrun", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) pop1();
    idle(2);
    chk("t5_drained", 32'(rx_valid), 0);

    // Reset in the middle of data bit 4 of 0x5A.
    exp_q.push_back(8'h77); send(8'h77, 1'b1, 1'b0, -1);
    idle(4);
    chk("t6_pre_count", 32'(rx_count), 1);
    fr5a = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 5 * BIT + 20; c++) begin
      @(posedge clk);
      #1 rxd = fr5a[c / BIT];
    end
    rst = 1'b1; rxd = 1'b1;
    idle(3);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rdata", 32'(rdata), 0);
    chk("t6_valid", 32'(rx_valid), 0);
    chk("t6_count", 32'(rx_count), 0);
    chk("t6_flags", 32'({frame_err, overrun, par_err}), 0);
    idle(2 * BIT);
    exp_q.push_back(8'h3C); send(8'h3C, 1'b1, 1'b0, -1);
    idle(4);
    chk("t6_count_after", 32'(rx_count), 1);
    pop1();

`ifdef UART_RX_PARITY_EN
    // Parity error still delivers the byte.
    exp_q.push_back(8'h07); send(8'h07, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_par_err", 32'(par_err), 1);
    chk("tp_head", 32'(rdata), 32'h07);
    pop1();
`endif
    idle(4);
    chk("final_par_err_or_clean", 32'(rx_count), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
